pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//   Sequential consumer of the ALU's ZERO output: owns the program counter and
//   resolves j/beq/bne using ZERO from the ALU compare (SUB via ADD, SELECT=001).
//   Sits between the control unit/ALU and instruction memory.
//   Holds PC while memory asserts BUSYWAIT, freezing the branch decision made at stall entry.
//   Keeps a saturating taken-branch count for the testbench.
// PARAMETERS
//   PC_WIDTH   32            width of PC and all address arithmetic
//   RESET_PC   32'h0000_0000 PC value loaded on reset
//   CNT_WIDTH  16            width of TAKEN_CNT (saturating)
// PORTS
//   CLK           in   1         clock, all state updates on rising edge
//   RESET         in   1         synchronous, active-high reset
//   BUSYWAIT      in   1         memory stall request; PC must hold while high
//   JUMP          in   1         unconditional jump (control unit)
//   BEQ           in   1         branch if ZERO==1
//   BNE           in   1         branch if ZERO==0
//   ZERO          in   1         ALU ZERO flag (RESULT==0)
//   OFFSET        in   8         signed word offset from instruction
//   PC            out  PC_WIDTH  current program counter
//   BRANCH_TAKEN  out  1         1 for the cycle after PC was loaded with a branch/jump target
//   STALLED       out  1         1 while FSM is in STALL
//   TAKEN_CNT     out  CNT_WIDTH saturating count of taken jumps/branches
// BEHAVIOUR
//   - Reset (RESET=1 at edge, overrides everything, incl. mid-stall):
//     PC=RESET_PC, state=RUN, pending regs cleared, BRANCH_TAKEN=0, STALLED=0, TAKEN_CNT=0.
//   - Arithmetic: PC_PLUS4 = PC+4; TARGET = PC+4 + (sext(OFFSET)<<2); all mod 2^PC_WIDTH.
//   - Decision (combinational, RUN only), priority JUMP > BEQ > BNE:
//     TAKEN = JUMP | (~JUMP & BEQ & ZERO) | (~JUMP & ~BEQ & BNE & ~ZERO).
//     BEQ & BNE both high without JUMP: BEQ rule applies, BNE ignored.
//   - FSM states: RUN, STALL. STALLED = (state==STALL), registered.
//   - RUN, BUSYWAIT=0 at edge: PC <= TAKEN ? TARGET : PC_PLUS4; BRANCH_TAKEN <= TAKEN;
//     TAKEN_CNT += TAKEN (saturates at all-ones); stay RUN.
//   - RUN, BUSYWAIT=1 at edge: PC holds; latch pend_pc <= (TAKEN ? TARGET : PC_PLUS4),
//     pend_taken <= TAKEN; BRANCH_TAKEN <= 0; -> STALL.
//   - STALL, BUSYWAIT=1: hold everything; JUMP/BEQ/BNE/ZERO/OFFSET ignored
//     (ZERO may glitch while ALU inputs change).
//   - STALL, BUSYWAIT=0 at edge: PC <= pend_pc; BRANCH_TAKEN <= pend_taken;
//     TAKEN_CNT += pend_taken; -> RUN. No extra bubble: 1 release edge.
//   - Latency: PC update 1 edge after decision; stall adds exactly N edges for N BUSYWAIT-high edges.
//   - BRANCH_TAKEN is a 1-cycle pulse; back-to-back taken branches keep it high.
//   - TAKEN_CNT never wraps; at max it holds max.
//   - X on control inputs while STALL has no effect; outputs never X after first reset.
// TESTING
//   1. RESET=1 one edge mid-run -> PC=0, STALLED=0, BRANCH_TAKEN=0, TAKEN_CNT=0.
//   2. No control, BUSYWAIT=0, 3 edges from reset -> PC=4,8,12; BRANCH_TAKEN stays 0.
//   3. PC=12, BEQ=1, ZERO=1, OFFSET=8'hFE -> PC=8, BRANCH_TAKEN=1, TAKEN_CNT=1;
//      then BNE=1, ZERO=1 -> PC=12, BRANCH_TAKEN=0.
//   4. PC=8, BEQ=1, ZERO=1, OFFSET=2, BUSYWAIT=1 for 3 edges with ZERO toggled to 0
//      -> PC=8, STALLED=1 throughout; BUSYWAIT=0 edge -> PC=20, BRANCH_TAKEN=1, STALLED=0.
//   5. RESET_PC=32'hFFFF_FFFC, no control, one edge -> PC=32'h0000_0000 (wrap);
//      JUMP=1, OFFSET=8'h80 from PC=0 -> PC=32'hFFFF_FE04.
//   6. Enter STALL with pending jump, assert RESET at next edge -> PC=RESET_PC, STALLED=0,
//      TAKEN_CNT=0; after release no pending target applied. Also CNT_WIDTH=2: 5 jumps -> TAKEN_CNT=3.

Source files
------------

// File: rtl/pc_branch_unit_if.sv
// pc_branch_unit_if
//   Groups the control, stall and status signals of pc_branch_unit.
//   master : the side that issues control and stall requests and observes the PC
//            (control unit / memory model / testbench).
//   slave  : the PC/branch unit itself.
//   Signals
//     busywait      memory stall request, PC holds while high
//     jump/beq/bne  branch controls from the control unit
//     zero          ALU ZERO flag
//     offset        signed 8-bit word offset
//     pc            current program counter
//     branch_taken  one-cycle pulse after a branch/jump target was loaded
//     stalled       high while the unit is in its stall state
//     taken_cnt     saturating count of taken jumps/branches
interface pc_branch_unit_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 busywait;
    logic                 jump;
    logic                 beq;
    logic                 bne;
    logic                 zero;
    logic [7:0]           offset;
    logic [PC_WIDTH-1:0]  pc;
    logic                 branch_taken;
    logic                 stalled;
    logic [CNT_WIDTH-1:0] taken_cnt;

    modport master (
        output busywait, jump, beq, bne, zero, offset,
        input  pc, branch_taken, stalled, taken_cnt
    );

    modport slave (
        input  busywait, jump, beq, bne, zero, offset,
        output pc, branch_taken, stalled, taken_cnt
    );
endinterface

// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Owns the program counter and resolves j/beq/bne from the ALU ZERO flag.
//   A memory stall freezes the decision taken on the stall-entry edge; the
//   frozen PC is applied on the single release edge, so a stall of N busy
//   edges adds exactly N edges of latency.
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    pc_branch_unit_if.slave (controls in, pc/status out)
//   Parameters
//     PC_WIDTH   width of the PC and all address arithmetic (>= 10)
//     RESET_PC   PC value loaded on reset
//     CNT_WIDTH  width of the saturating taken counter (>= 2)
module pc_branch_unit #(
    parameter int                     PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = {PC_WIDTH{1'b0}},
    parameter int                     CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    pc_branch_unit_if.slave  bus
);

    localparam logic [PC_WIDTH-1:0]  PC_FOUR = {{(PC_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;

    logic [PC_WIDTH-1:0]  pc_r;
    logic [PC_WIDTH-1:0]  pc_nxt_s;
    logic [PC_WIDTH-1:0]  pend_pc_r;
    logic [PC_WIDTH-1:0]  pend_pc_nxt_s;
    logic                 pend_taken_r;
    logic                 pend_taken_nxt_s;
    logic                 branch_taken_r;
    logic                 branch_taken_nxt_s;
    logic                 stalled_r;
    logic [CNT_WIDTH-1:0] taken_cnt_r;
    logic [CNT_WIDTH-1:0] taken_cnt_nxt_s;

    logic [PC_WIDTH-1:0]  pc_plus4_s;
    logic [PC_WIDTH-1:0]  offset_ext_s;
    logic [PC_WIDTH-1:0]  target_s;
    logic [PC_WIDTH-1:0]  decided_pc_s;
    logic                 taken_s;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc
    );
        logic [CNT_WIDTH-1:0] res;
        if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Branch decision and address arithmetic; only consumed while running.
    always_comb begin
        pc_plus4_s   = pc_r + PC_FOUR;
        offset_ext_s = {{(PC_WIDTH-10){bus.offset[7]}}, bus.offset, 2'b00};
        target_s     = pc_plus4_s + offset_ext_s;
        // Priority JUMP > BEQ > BNE; with BEQ and BNE both set, BNE is ignored.
        taken_s      = bus.jump
                     | (~bus.jump & bus.beq & bus.zero)
                     | (~bus.jump & ~bus.beq & bus.bne & ~bus.zero);
        if (taken_s) begin
            decided_pc_s = target_s;
        end else begin
            decided_pc_s = pc_plus4_s;
        end
    end

    // State and datapath registers; reset overrides everything, including a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_RUN;
            pc_r           <= RESET_PC;
            pend_pc_r      <= {PC_WIDTH{1'b0}};
            pend_taken_r   <= 1'b0;
            branch_taken_r <= 1'b0;
            stalled_r      <= 1'b0;
            taken_cnt_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            pc_r           <= pc_nxt_s;
            pend_pc_r      <= pend_pc_nxt_s;
            pend_taken_r   <= pend_taken_nxt_s;
            branch_taken_r <= branch_taken_nxt_s;
            stalled_r      <= (state_nxt_s == ST_STALL);
            taken_cnt_r    <= taken_cnt_nxt_s;
        end
    end

    // Next-state logic: stay in STALL for as long as memory asserts busywait.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (bus.busywait) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STALL: begin
                if (bus.busywait) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Datapath next values. Controls are only looked at in RUN, so ZERO glitches
    // or unknown controls during a stall cannot disturb the frozen decision.
    always_comb begin
        pc_nxt_s           = pc_r;
        pend_pc_nxt_s      = pend_pc_r;
        pend_taken_nxt_s   = pend_taken_r;
        branch_taken_nxt_s = branch_taken_r;
        taken_cnt_nxt_s    = taken_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (bus.busywait) begin
                    pend_pc_nxt_s      = decided_pc_s;
                    pend_taken_nxt_s   = taken_s;
                    branch_taken_nxt_s = 1'b0;
                end else begin
                    pc_nxt_s           = decided_pc_s;
                    branch_taken_nxt_s = taken_s;
                    taken_cnt_nxt_s    = sat_inc(taken_cnt_r, taken_s);
                end
            end
            ST_STALL: begin
                if (bus.busywait) begin
                    branch_taken_nxt_s = branch_taken_r;
                end else begin
                    pc_nxt_s           = pend_pc_r;
                    branch_taken_nxt_s = pend_taken_r;
                    taken_cnt_nxt_s    = sat_inc(taken_cnt_r, pend_taken_r);
                end
            end
            default: begin
                pc_nxt_s = pc_r;
            end
        endcase
    end

    assign bus.pc           = pc_r;
    assign bus.branch_taken = branch_taken_r;
    assign bus.stalled      = stalled_r;
    assign bus.taken_cnt    = taken_cnt_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit
//   Drives two pc_branch_unit instances with identical stimulus:
//     u0 : default parameters (RESET_PC = 0, 16-bit counter)
//     u1 : RESET_PC = 32'hFFFF_FFFC, 2-bit counter (wrap and saturation cases)
//   Stimulus is applied on the falling edge; a reference model computes the
//   outputs expected after the following rising edge and queues them. A
//   separate monitor pops the queues 1 time unit after each rising edge.
module tb_pc_branch_unit;

    typedef struct {
        logic [31:0] pc;
        logic        bt;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic reset;

    pc_branch_unit_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) bus0 ();
    pc_branch_unit_if #(.PC_WIDTH(32), .CNT_WIDTH(2))  bus1 ();

    pc_branch_unit #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0000_0000),
        .CNT_WIDTH(16)
    ) u0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0.slave)
    );

    pc_branch_unit #(
        .PC_WIDTH (32),
        .RESET_PC (32'hFFFF_FFFC),
        .CNT_WIDTH(2)
    ) u1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1.slave)
    );

    int total = 0;
    int bad   = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state (plain integers, PC kept modulo 2^32).
    longint m_pc   [2];
    longint m_ppc  [2];
    bit     m_stall[2];
    bit     m_ptk  [2];
    bit     m_bt   [2];
    int     m_cnt  [2];
    longint rpc    [2];
    int     cmax   [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Outputs expected after the next rising edge, given the inputs of this cycle.
    task automatic model_step(input int i, input bit rst, input bit bsy, input bit j,
                              input bit bq, input bit bn, input bit z, input logic [7:0] off);
        longint nxt;
        bit     tk;
        int     soff;
        exp_t   e;
        soff = int'($signed(off));
        if (rst) begin
            m_pc[i]    = rpc[i];
            m_ppc[i]   = 0;
            m_stall[i] = 0;
            m_ptk[i]   = 0;
            m_bt[i]    = 0;
            m_cnt[i]   = 0;
        end else if (!m_stall[i]) begin
            if (j)       tk = 1;
            else if (bq) tk = z;
            else if (bn) tk = !z;
            else         tk = 0;
            nxt = tk ? (m_pc[i] + 4 + 4 * longint'(soff)) : (m_pc[i] + 4);
            nxt = nxt & 64'h0000_0000_FFFF_FFFF;
            if (bsy) begin
                m_ppc[i]   = nxt;
                m_ptk[i]   = tk;
                m_bt[i]    = 0;
                m_stall[i] = 1;
            end else begin
                m_pc[i]  = nxt;
                m_bt[i]  = tk;
                m_cnt[i] = (tk && m_cnt[i] < cmax[i]) ? m_cnt[i] + 1 : m_cnt[i];
            end
        end else if (!bsy) begin
            m_pc[i]    = m_ppc[i];
            m_bt[i]    = m_ptk[i];
            m_cnt[i]   = (m_ptk[i] && m_cnt[i] < cmax[i]) ? m_cnt[i] + 1 : m_cnt[i];
            m_stall[i] = 0;
        end
        e.pc  = m_pc[i][31:0];
        e.bt  = m_bt[i];
        e.st  = m_stall[i];
        e.cnt = m_cnt[i][15:0];
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // One clock cycle: drive inputs at the falling edge, queue expectations,
    // return at the next falling edge.
    task automatic step(input bit rst, input bit bsy, input bit j, input bit bq,
                        input bit bn, input bit z, input logic [7:0] off);
        reset         = rst;
        bus0.busywait = bsy; bus1.busywait = bsy;
        bus0.jump     = j;   bus1.jump     = j;
        bus0.beq      = bq;  bus1.beq      = bq;
        bus0.bne      = bn;  bus1.bne      = bn;
        bus0.zero     = z;   bus1.zero     = z;
        bus0.offset   = off; bus1.offset   = off;
        model_step(0, rst, bsy, j, bq, bn, z, off);
        model_step(1, rst, bsy, j, bq, bn, z, off);
        @(negedge clk);
    endtask

    // Monitor: compare each DUT against its queued expectation after every rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("u0.pc",  longint'(bus0.pc),           longint'(e.pc));
            chk("u0.bt",  longint'(bus0.branch_taken), longint'(e.bt));
            chk("u0.st",  longint'(bus0.stalled),      longint'(e.st));
            chk("u0.cnt", longint'(bus0.taken_cnt),    longint'(e.cnt));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("u1.pc",  longint'(bus1.pc),           longint'(e.pc));
            chk("u1.bt",  longint'(bus1.branch_taken), longint'(e.bt));
            chk("u1.st",  longint'(bus1.stalled),      longint'(e.st));
            chk("u1.cnt", longint'(bus1.taken_cnt),    longint'(e.cnt));
        end
    end

    initial begin
        rpc[0] = 64'h0;           cmax[0] = 65535;
        rpc[1] = 64'hFFFF_FFFC;   cmax[1] = 3;
        reset = 1'b1;
        bus0.busywait = 1'b0; bus0.jump = 1'b0; bus0.beq = 1'b0; bus0.bne = 1'b0;
        bus0.zero = 1'b0; bus0.offset = 8'h00;
        bus1.busywait = 1'b0; bus1.jump = 1'b0; bus1.beq = 1'b0; bus1.bne = 1'b0;
        bus1.zero = 1'b0; bus1.offset = 8'h00;
        @(negedge clk);

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("rst.pc0",  longint'(bus0.pc), 64'h0);
        chk("rst.pc1",  longint'(bus1.pc), 64'hFFFF_FFFC);
        chk("rst.st",   longint'(bus0.stalled), 64'h0);
        chk("rst.cnt",  longint'(bus0.taken_cnt), 64'h0);

        // Sequential fetch; u1 wraps from FFFF_FFFC to 0.
        step(0, 0, 0, 0, 0, 0, 8'h00);
        chk("wrap.pc1", longint'(bus1.pc), 64'h0);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        chk("seq.pc0",  longint'(bus0.pc), 64'd12);
        chk("seq.bt0",  longint'(bus0.branch_taken), 64'h0);

        // Backward beq taken, then bne not taken.
        step(0, 0, 0, 1, 0, 1, 8'hFE);
        chk("beq.pc0",  longint'(bus0.pc), 64'd8);
        chk("beq.bt0",  longint'(bus0.branch_taken), 64'h1);
        chk("beq.cnt0", longint'(bus0.taken_cnt), 64'h1);
        step(0, 0, 0, 0, 1, 1, 8'hFE);
        chk("bne.pc0",  longint'(bus0.pc), 64'd12);
        chk("bne.bt0",  longint'(bus0.branch_taken), 64'h0);

        // beq decided at stall entry; ZERO drops during the stall and is ignored.
        step(0, 1, 0, 1, 0, 1, 8'h02);
        chk("stl.pc0",  longint'(bus0.pc), 64'd12);
        chk("stl.st0",  longint'(bus0.stalled), 64'h1);
        step(0, 1, 0, 1, 0, 0, 8'h02);
        step(0, 1, 1, 0, 1, 0, 8'h7F);
        chk("stl.pc0b", longint'(bus0.pc), 64'd12);
        chk("stl.bt0",  longint'(bus0.branch_taken), 64'h0);
        step(0, 0, 0, 0, 1, 0, 8'h40);
        chk("rel.pc0",  longint'(bus0.pc), 64'd24);
        chk("rel.bt0",  longint'(bus0.branch_taken), 64'h1);
        chk("rel.st0",  longint'(bus0.stalled), 64'h0);

        // Most negative jump offset from PC=0 on u1.
        step(1, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 0, 8'h80);
        chk("jneg.pc1", longint'(bus1.pc), 64'hFFFF_FE04);

        // Reset during a stall with a pending jump discards the pending target.
        step(0, 1, 1, 0, 0, 0, 8'h10);
        step(1, 1, 0, 0, 0, 0, 8'h00);
        chk("rstl.pc0", longint'(bus0.pc), 64'h0);
        chk("rstl.st0", longint'(bus0.stalled), 64'h0);
        chk("rstl.cnt", longint'(bus0.taken_cnt), 64'h0);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        chk("rstl.nxt", longint'(bus0.pc), 64'd4);

        // Counter saturation on the 2-bit instance.
        for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("sat.cnt1", longint'(bus1.taken_cnt), 64'd3);
        chk("sat.cnt0", longint'(bus0.taken_cnt), 64'd5);
        chk("sat.bt1",  longint'(bus1.branch_taken), 64'h1);

        // Randomized traffic with stalls, occasional resets and junk during stalls.
        for (int n = 0; n < 3000; n++) begin
            bit r;
            bit b;
            r = ($urandom_range(0, 63) == 0);
            b = ($urandom_range(0, 2) == 0);
            step(r, b, ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 255)));
        end

        chk("drain.q0", longint'(q0.size()), 64'h0);
        chk("drain.q1", longint'(q1.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
